// File: rtl/issue_sel_pkg.sv
// Shared definitions for the issue-port select controller: sizes, FSM encoding
// and a one-hot to binary index helper.
package issue_sel_pkg;

   localparam int NUM_ENT = 8;
   localparam int IDX_W   = 3;
   localparam int LAT_W   = 6;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      HOLD  = 2'd1,
      BUSY  = 2'd2
   } state_e;

   function automatic logic [IDX_W-1:0] onehotToIdx(input logic [NUM_ENT-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_ENT; i++) begin
         if (oh[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/issue_sel_ctrl_if.sv
// Issue-port bundle between the issue window and the FU: ready bits and
// multicycle info in, registered one-hot grant and busy status out.
interface issue_sel_ctrl_if;
   import issue_sel_pkg::*;

   logic [NUM_ENT-1:0] req;
   logic [NUM_ENT-1:0] mc;
   logic [LAT_W-1:0]   mc_lat;
   logic               fu_ready;
   logic               grant_vld;
   logic [NUM_ENT-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               busy;

   modport master (
      input  req, mc, mc_lat, fu_ready,
      output grant_vld, grant, grant_idx, busy
   );

   modport slave (
      output req, mc, mc_lat, fu_ready,
      input  grant_vld, grant, grant_idx, busy
   );

endinterface

// File: rtl/issue_sel_ctrl_rr_pick8.sv
// Combinational 8-way pick: rotate requests so the pointer entry is bit 0,
// take the lowest set bit with a running prefix mask, then rotate back.
module rr_pick8
   import issue_sel_pkg::*;
(
   input  logic [NUM_ENT-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_ENT-1:0] gnt_o,
   output logic               any_o
);

   logic [NUM_ENT-1:0] rotReq;
   logic [NUM_ENT-1:0] rotGnt;
   logic               seen;

   always_comb begin
      rotReq = '0;
      rotGnt = '0;
      gnt_o  = '0;
      seen   = 1'b0;
      for (int i = 0; i < NUM_ENT; i++) begin
         rotReq[i] = req_i[IDX_W'(i + int'(ptr_i))];
      end
      for (int i = 0; i < NUM_ENT; i++) begin
         rotGnt[i] = rotReq[i] & ~seen;
         seen      = seen | rotReq[i];
      end
      for (int i = 0; i < NUM_ENT; i++) begin
         gnt_o[IDX_W'(i + int'(ptr_i))] = rotGnt[i];
      end
      any_o = |req_i;
   end

endmodule

// File: rtl/issue_sel_ctrl.sv
// Issue-port sequencing controller: registered one-hot grant with valid/ready,
// multicycle busy countdown, flush. Define ISSUE_SEL_RR_EN for rotating priority.
module issue_sel_ctrl
   import issue_sel_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   issue_sel_ctrl_if.master  bus_if
);

   state_e             state_q, state_d;
   logic               grantVld_q, grantVld_d;
   logic [NUM_ENT-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   grantIdx_q, grantIdx_d;
   logic               mcFlag_q, mcFlag_d;
   logic [LAT_W-1:0]   busyCnt_q, busyCnt_d;

   logic               accept;
   logic [NUM_ENT-1:0] pickMask;
   logic [NUM_ENT-1:0] pickGnt;
   logic               pickAny;
   logic [IDX_W-1:0]   pickIdx;
   logic               pickMc;
   logic [IDX_W-1:0]   selPtr;

   // The queue only clears an accepted entry at the edge, so mask it here.
   assign accept   = grantVld_q & bus_if.fu_ready;
   assign pickMask = bus_if.req & ~(accept ? grant_q : '0);
   assign pickIdx  = onehotToIdx(pickGnt);
   assign pickMc   = |(pickGnt & bus_if.mc);

`ifdef ISSUE_SEL_RR_EN
   logic [IDX_W-1:0] rrPtr_q, rrPtr_d;

   always_comb begin
      rrPtr_d = rrPtr_q;
      if (!flush_i && accept) rrPtr_d = grantIdx_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rrPtr_q <= '0;
      else         rrPtr_q <= rrPtr_d;
   end

   assign selPtr = rrPtr_d;
`else
   assign selPtr = '0;
`endif

   rr_pick8 u_pick (
      .req_i (pickMask),
      .ptr_i (selPtr),
      .gnt_o (pickGnt),
      .any_o (pickAny)
   );

   always_comb begin
      state_d    = state_q;
      grantVld_d = grantVld_q;
      grant_d    = grant_q;
      grantIdx_d = grantIdx_q;
      mcFlag_d   = mcFlag_q;
      busyCnt_d  = busyCnt_q;
      if (flush_i) begin
         state_d    = ISSUE;
         grantVld_d = 1'b0;
         grant_d    = '0;
         grantIdx_d = '0;
         mcFlag_d   = 1'b0;
         busyCnt_d  = '0;
      end else begin
         case (state_q)
            ISSUE: begin
               if (pickAny) begin
                  state_d    = HOLD;
                  grantVld_d = 1'b1;
                  grant_d    = pickGnt;
                  grantIdx_d = pickIdx;
                  mcFlag_d   = pickMc;
               end
            end
            HOLD: begin
               if (accept) begin
                  if (mcFlag_q && (bus_if.mc_lat != '0)) begin
                     state_d    = BUSY;
                     grantVld_d = 1'b0;
                     grant_d    = '0;
                     grantIdx_d = '0;
                     mcFlag_d   = 1'b0;
                     busyCnt_d  = bus_if.mc_lat;
                  end else if (pickAny) begin
                     grant_d    = pickGnt;
                     grantIdx_d = pickIdx;
                     mcFlag_d   = pickMc;
                  end else begin
                     state_d    = ISSUE;
                     grantVld_d = 1'b0;
                     grant_d    = '0;
                     grantIdx_d = '0;
                     mcFlag_d   = 1'b0;
                  end
               end
            end
            BUSY: begin
               // Pick during the last busy cycle so the grant lands as the count hits zero.
               if (busyCnt_q > LAT_W'(1)) begin
                  busyCnt_d = busyCnt_q - 1'b1;
               end else begin
                  busyCnt_d = '0;
                  if (pickAny) begin
                     state_d    = HOLD;
                     grantVld_d = 1'b1;
                     grant_d    = pickGnt;
                     grantIdx_d = pickIdx;
                     mcFlag_d   = pickMc;
                  end else begin
                     state_d = ISSUE;
                  end
               end
            end
            default: begin
               state_d    = ISSUE;
               grantVld_d = 1'b0;
               grant_d    = '0;
               grantIdx_d = '0;
               mcFlag_d   = 1'b0;
               busyCnt_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ISSUE;
         grantVld_q <= 1'b0;
         grant_q    <= '0;
         grantIdx_q <= '0;
         mcFlag_q   <= 1'b0;
         busyCnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         grantVld_q <= grantVld_d;
         grant_q    <= grant_d;
         grantIdx_q <= grantIdx_d;
         mcFlag_q   <= mcFlag_d;
         busyCnt_q  <= busyCnt_d;
      end
   end

   assign bus_if.grant_vld = grantVld_q;
   assign bus_if.grant     = grant_q;
   assign bus_if.grant_idx = grantIdx_q;
   assign bus_if.busy      = (busyCnt_q != '0);

endmodule

// File: doc/issue_sel_ctrl.md
Name: issue_sel_ctrl

Overview:
Sequencing controller for one functional-unit issue port of an 8-entry issue window. Each cycle it picks one ready entry by rotating or fixed priority and presents a registered one-hot grant to the FU under a valid/ready handshake. It blocks further issue while a multicycle op (e.g. divide) occupies the FU. It sits between the issue-queue ready bits and the FU operand-read stage, alongside the combinational select tree.

Parameters:
NUM_ENT, 8, issue-window entries (fixed at 8; one-hot width)
IDX_W, 3, log2(NUM_ENT)
LAT_W, 6, width of multicycle latency input and busy counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous assert, active-low
flush_i  in  1  synchronous pipeline flush
req_i  in  NUM_ENT  per-entry ready-to-issue
mc_i  in  NUM_ENT  per-entry multicycle-op flag
mc_lat_i  in  LAT_W  FU occupancy in cycles for a multicycle op
fu_ready_i  in  1  FU accepts grant this cycle
grant_vld_o  out  1  grant valid
grant_o  out  NUM_ENT  one-hot granted entry, zero when grant_vld_o=0
grant_idx_o  out  IDX_W  binary index of granted entry
busy_o  out  1  FU occupied by a multicycle op

Behaviour:
- Reset (rst_ni=0, async): grant_vld_o=0, grant_o=0, grant_idx_o=0, busy_o=0, busy counter=0, rr pointer=0, state=ISSUE.
- States: ISSUE (no grant held), HOLD (grant presented, not yet accepted), BUSY (multicycle countdown).
- Accept = grant_vld_o & fu_ready_i at a clock edge.
- Selection is combinational from req_i masked by pick_mask. When an accept occurs in the same cycle, the accepted index is removed from pick_mask, because the queue clears it only at that edge.
- The selected entry is registered, giving 1-cycle latency from req_i to grant_vld_o. The registered state also captures mc_i of the picked entry.
- ISSUE: if any masked req is set, load grant and go to HOLD; otherwise stay in ISSUE.
- HOLD, no accept: grant_o, grant_idx_o and the mc flag stay stable, even if req_i changes.
- HOLD, accept, non-mc grant: a new selection is loaded the same edge if available (back-to-back issue every cycle); otherwise go to ISSUE.
- HOLD, accept, mc grant with mc_lat_i≠0: load counter=mc_lat_i, go to BUSY, grant_vld_o=0 next cycle.
- HOLD, accept, mc grant with mc_lat_i=0: treated as non-mc.
- BUSY: busy_o=(counter≠0). Counter decrements each cycle. When counter=1, selection is loaded so grant_vld_o rises the cycle counter reaches 0.
- Net effect of BUSY: after an mc accept, grant_vld_o stays low exactly mc_lat_i cycles.
- Rotating priority: on accept of index k, pointer ← (k+1) mod 8, wrapping 7→0. Search order is pointer, pointer+1, …, pointer-1.
- Flush: flush_i has priority over accept and selection. Next cycle grant_vld_o=0, grant_o=0, counter=0, busy_o=0, state=ISSUE. The pointer is preserved.
- Flush while in BUSY aborts the countdown.
- Reset mid-operation returns all outputs to reset values immediately.

Optional Feature:
ISSUE_SEL_RR_EN
- Defined: rotating-priority selection with pointer update as above.
- Undefined: fixed priority with the lowest index winning, matching the combinational select tree. The pointer register is removed and grant ordering is deterministic by index.

Decomposition:
- Shared package issue_sel_pkg holds NUM_ENT, IDX_W, LAT_W defaults, state encoding (ISSUE=2'd0, HOLD=2'd1, BUSY=2'd2), and a onehot-to-index function.
- One sub-module: rr_pick8, combinational. It takes an 8-bit request and 3-bit pointer and returns a one-hot grant plus an any-request flag. It is implemented as a rotate, then a prefix-mask priority pick, then a rotate back.
- With ISSUE_SEL_RR_EN undefined, the pointer to rr_pick8 is tied to 0.

Test Plan:
1. Reset, then req_i=8'b0000_0100 with fu_ready_i=1 → next cycle grant_vld_o=1, grant_o=8'h04, grant_idx_o=2; next cycle pointer=3.
2. RR enabled, req_i=8'hFF held, fu_ready_i=1 → grant_idx_o sequence 0,1,2,…,7,0 on consecutive cycles, with no gaps and no duplicates.
3. Grant idx 5 presented, fu_ready_i=0 for 3 cycles while req_i changes to 8'h01 → grant_o holds 8'h20 for all 3 cycles. It is accepted when fu_ready_i=1.
4. mc_i[3]=1, mc_lat_i=4, req_i=8'h08 then 8'h10, accept idx 3 → busy_o=1 and grant_vld_o=0 for exactly 4 cycles; the cycle after, grant_idx_o=4.
5. flush_i=1 during BUSY (counter=2) with fu_ready_i=1 → next cycle busy_o=0, grant_vld_o=0, pointer unchanged. Normal issue resumes one cycle after flush deasserts.
6. RR disabled, req_i=8'b1010_0000, accept each grant → order idx 5 then 7. Asserting rst_ni=0 mid-HOLD clears grant_vld_o asynchronously.
